// File: rtl/scoreboard_register_file_if.sv
// Bus bundle for scoreboard_register_file: two read ports with busy
// flags, the decode-side issue handshake and the write-back port.
// The master side is the CPU pipeline; the slave side is the register file.
interface scoreboard_register_file_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_ready;
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_underflow;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, wb_underflow
    );

    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, wb_underflow
    );
endinterface

// File: rtl/scoreboard_register_file.sv
// Parametrised register file with a per-register pending-write scoreboard.
// Decode reads operands and reserves destinations (issue); write-back
// writes results and retires reservations. Each register has a saturating
// pending counter; a non-zero count marks the register busy (RAW hazard).
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write-back data
// and post-write-back busy state to the read ports in the same cycle;
// without it, writes become visible one cycle after the clock edge.
module scoreboard_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int ZERO_REG   = 0,
    parameter int PEND_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    scoreboard_register_file_if.slave bus
);
    localparam int                    NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [PEND_WIDTH-1:0] PMAX      = {PEND_WIDTH{1'b1}};
    localparam logic [PEND_WIDTH-1:0] PEND_ZERO = {PEND_WIDTH{1'b0}};
    localparam logic [PEND_WIDTH-1:0] PEND_ONE  = PEND_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic                  HW_ZERO   = (ZERO_REG != 0);

    // Architectural state
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend_r [NUM_REGS];
    logic                  underflow_r;

    // Combinational decode
    logic                  issue_ready_s;
    logic                  issue_acc_s;
    logic [NUM_REGS-1:0]   inc_s;
    logic [NUM_REGS-1:0]   dec_s;
    logic [PEND_WIDTH-1:0] pend_nxt_s [NUM_REGS];
    logic                  underflow_set_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s [2];
    logic [DATA_WIDTH-1:0] rd_data_s [2];
    logic [1:0]            rd_busy_s;

    assign rd_addr_s[0] = bus.rs1_addr;
    assign rd_addr_s[1] = bus.rs2_addr;

    // Issue acceptance: ready unless the destination counter is saturated
    always_comb begin
        issue_ready_s = 1'b1;
        if (HW_ZERO && (bus.issue_rd == ADDR_ZERO)) begin
            issue_ready_s = 1'b1;
        end else begin
            issue_ready_s = (pend_r[bus.issue_rd] != PMAX);
        end
        issue_acc_s = bus.issue_valid && issue_ready_s;
    end

    // Per-register increment/decrement decode and next pending count
    always_comb begin
        underflow_set_s = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            // A hardwired zero register neither reserves nor retires
            inc_s[r] = issue_acc_s && (bus.issue_rd == ADDR_WIDTH'(r))
                       && !(HW_ZERO && (r == 0));
            dec_s[r] = bus.wb_valid && (bus.wb_rd == ADDR_WIDTH'(r))
                       && !(HW_ZERO && (r == 0));
            pend_nxt_s[r] = pend_r[r];
            case ({inc_s[r], dec_s[r]})
                2'b10: begin
                    pend_nxt_s[r] = pend_r[r] + PEND_ONE;
                end
                2'b01: begin
                    if (pend_r[r] == PEND_ZERO) begin
                        underflow_set_s = 1'b1;
                        pend_nxt_s[r]   = PEND_ZERO;
                    end else begin
                        pend_nxt_s[r] = pend_r[r] - PEND_ONE;
                    end
                end
                default: begin
                    // Both or neither: reservation count is unchanged
                    pend_nxt_s[r] = pend_r[r];
                end
            endcase
        end
    end

    // Read ports: register contents and busy flag, optional write-back bypass
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = regs_r[rd_addr_s[p]];
            rd_busy_s[p] = (pend_r[rd_addr_s[p]] != PEND_ZERO);
            if (HW_ZERO && (rd_addr_s[p] == ADDR_ZERO)) begin
                rd_data_s[p] = DATA_ZERO;
                rd_busy_s[p] = 1'b0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                // Bypass is gated by reset so outputs hold reset values in reset
                if (reset_n && bus.wb_valid && (bus.wb_rd == rd_addr_s[p])) begin
                    rd_data_s[p] = bus.wb_data;
                    if ((pend_r[rd_addr_s[p]] == PEND_ONE) &&
                        !(issue_acc_s && (bus.issue_rd == rd_addr_s[p]))) begin
                        rd_busy_s[p] = 1'b0;
                    end else begin
                        rd_busy_s[p] = rd_busy_s[p];
                    end
                end else begin
                    rd_data_s[p] = rd_data_s[p];
                end
`else
                rd_data_s[p] = rd_data_s[p];
`endif
            end
        end
    end

    // Register writes, pending counters and sticky underflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_r[r] <= DATA_ZERO;
                pend_r[r] <= PEND_ZERO;
            end
            underflow_r <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (dec_s[r]) begin
                    regs_r[r] <= bus.wb_data;
                end else begin
                    regs_r[r] <= regs_r[r];
                end
                pend_r[r] <= pend_nxt_s[r];
            end
            underflow_r <= underflow_r | underflow_set_s;
        end
    end

    assign bus.rs1_data     = rd_data_s[0];
    assign bus.rs2_data     = rd_data_s[1];
    assign bus.rs1_busy     = rd_busy_s[0];
    assign bus.rs2_busy     = rd_busy_s[1];
    assign bus.issue_ready  = issue_ready_s;
    assign bus.wb_underflow = underflow_r;

endmodule

// File: doc/scoreboard_register_file.md
Name: scoreboard_register_file

Overview:
- Parametrised successor to the team's 2-port register file: configurable data width and register count, two combinational read ports, one write-back port.
- Adds a per-register pending-write scoreboard so the pipelined CPU's decode stage can detect RAW hazards.
- Sits between decode (reads, issue) and write-back (writes, retire).

Parameters:
- DATA_WIDTH, 16, width of each register and of all data ports.
- ADDR_WIDTH, 2, register address width; NUM_REGS = 2**ADDR_WIDTH.
- ZERO_REG, 0, 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register.
- PEND_WIDTH, 2, width of each per-register pending counter; saturation value PMAX = 2**PEND_WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_addr  in  ADDR_WIDTH  read port 1 address.
- rs2_addr  in  ADDR_WIDTH  read port 2 address.
- rs1_data  out  DATA_WIDTH  read port 1 data, combinational.
- rs2_data  out  DATA_WIDTH  read port 2 data, combinational.
- rs1_busy  out  1  pending write outstanding on rs1_addr.
- rs2_busy  out  1  pending write outstanding on rs2_addr.
- issue_valid  in  1  decode requests to reserve destination issue_rd.
- issue_rd  in  ADDR_WIDTH  destination register being reserved.
- issue_ready  out  1  reservation can be accepted this cycle.
- wb_valid  in  1  write-back strobe.
- wb_rd  in  ADDR_WIDTH  write-back destination.
- wb_data  in  DATA_WIDTH  write-back data.
- wb_underflow  out  1  sticky error: write-back to a register with no pending reservation.

Behaviour:
- Reset (reset_n low, asynchronous): all registers = 0; all pending counters = 0; wb_underflow = 0. While in reset, rs*_data = 0, rs*_busy = 0, issue_ready = 1.
- Reads: rs*_data = reg[rs*_addr], zero latency. rs*_busy = (pend[rs*_addr] != 0).
- Issue handshake: a reservation is accepted when issue_valid && issue_ready at the rising edge. issue_ready = (pend[issue_rd] != PMAX), combinational from the counter only.
- Write: when wb_valid, reg[wb_rd] <= wb_data at the rising edge; the new value is readable the following cycle.
- Counter update per register r, at the rising edge:
  - accepted issue to r, no wb to r: pend+1.
  - wb to r, no accepted issue to r: pend-1; if pend==0, it stays 0 and wb_underflow is set (data is still written).
  - both to r in the same cycle: pend unchanged.
  - neither: unchanged.
- Issue and wb to different registers in one cycle: both counters update independently.
- Saturation: at pend==PMAX, issue_ready=0 and the counter never wraps. A wb to r in that cycle decrements it; issue_ready rises the next cycle.
- ZERO_REG=1:
  - reg0 always reads 0; writes to reg0 are ignored.
  - Issue to reg0 always reports ready and never increments.
  - rs*_busy for reg0 is always 0; wb to reg0 never sets wb_underflow.
- wb_underflow is cleared only by reset.
- Reset asserted mid-operation: all state clears immediately; in-flight reservations are lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wb_valid && wb_rd==rs*_addr (excluding hardwired reg0), rs*_data = wb_data in the same cycle. rs*_busy reflects the post-write-back count: it deasserts when pend==1 and that write-back is in flight with no same-cycle accepted issue to that register.
- Undefined: reads return the old register contents and rs*_busy the current counter until the clock edge, i.e. 1-cycle write-to-read latency.

Test Plan:
- Reset then read all NUM_REGS addresses -> every rs*_data=0, rs*_busy=0, issue_ready=1, wb_underflow=0.
- Issue rd=2; next cycle rs1_addr=2 -> rs1_busy=1. wb rd=2 data=16'hBEEF; next cycle -> rs1_data=BEEF, rs1_busy=0.
- Three issues to rd=1 -> issue_ready=0 with issue_rd=1. Fourth issue attempt -> pend stays 3. One wb -> next cycle issue_ready=1.
- Same-cycle issue and wb to rd=3 with pend=1 -> pend stays 1, busy stays 1. wb to rd=0 with pend=0 (ZERO_REG=0) -> data written, wb_underflow=1 and sticky.
- ZERO_REG=1: wb rd=0 data=FFFF -> rs1_data=0; issue rd=0 -> busy never set.
- REGFILE_BYPASS_EN defined: pend[1]=1, wb rd=1 data=1234 with rs2_addr=1 -> same cycle rs2_data=1234, rs2_busy=0. Undefined: old data that cycle, 1234 the next. Pulse reset_n low mid-sequence -> all outputs reset values immediately.
